// File: rtl/rob_retire_unit.sv
// rob_retire_unit: in-order reorder buffer with a dual-retire commit stage.
// It allocates one entry per cycle at dispatch. Two writeback ports record
// completion. Each cycle it retires up to the two oldest completed entries onto
// two architectural register file write ports.
//
// Optional feature: define ROB_FLUSH_EN to add a synchronous 'flush' input.
// A flush empties the buffer and overrides alloc, writeback and retire that cycle.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   alloc_valid/has_dest/preg      dispatch request
//   alloc_ready, alloc_tag         comb: not full, tag for accepted request
//   wb1_*/wb2_*                    writeback completions (wb1 wins on same tag)
//   retire1/write_addr1/data1      registered write port, oldest entry
//   retire2/write_addr2/data2      registered write port, second-oldest entry
//   commit_cnt                     registered entries freed this cycle
//   count, empty, full             occupancy
//   flush                          (ROB_FLUSH_EN only) clear all entries
module rob_retire_unit #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned PREG_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
`ifdef ROB_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              alloc_valid,
    input  logic              alloc_has_dest,
    input  logic [PREG_W-1:0] alloc_preg,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb1_valid,
    input  logic [TAG_W-1:0]  wb1_tag,
    input  logic [DATA_W-1:0] wb1_data,
    input  logic              wb2_valid,
    input  logic [TAG_W-1:0]  wb2_tag,
    input  logic [DATA_W-1:0] wb2_data,
    output logic              retire1,
    output logic [PREG_W-1:0] write_addr1,
    output logic [DATA_W-1:0] write_data1,
    output logic              retire2,
    output logic [PREG_W-1:0] write_addr2,
    output logic [DATA_W-1:0] write_data2,
    output logic [1:0]        commit_cnt,
    output logic [TAG_W:0]    count,
    output logic              empty,
    output logic              full
);

    localparam int unsigned CNT_W = TAG_W + 1;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [DEPTH-1:0]  ent_has_dest;
    logic [PREG_W-1:0] ent_preg [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;

    logic [TAG_W-1:0]  head1;
    logic              r0;
    logic              r1;
    logic [1:0]        commit_c;
    logic              alloc_fire;
    logic              flush_i;

`ifdef ROB_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Occupancy flags; ready uses count before this cycle's retirement.
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign alloc_ready = !full;
    assign alloc_tag   = tail;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Strict in-order retire select on registered state.
    always_comb begin
        head1    = head + TAG_W'(1);
        r0       = ent_valid[head] && ent_done[head];
        r1       = r0 && ent_valid[head1] && ent_done[head1];
        commit_c = 2'({1'b0, r0} + {1'b0, r1});
    end

    // Entry array, pointers and registered retire ports.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent_valid    <= '0;
            ent_done     <= '0;
            ent_has_dest <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_preg[i] <= '0;
                ent_data[i] <= '0;
            end
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            retire1     <= 1'b0;
            retire2     <= 1'b0;
            write_addr1 <= '0;
            write_data1 <= '0;
            write_addr2 <= '0;
            write_data2 <= '0;
            commit_cnt  <= '0;
        end else if (flush_i) begin
            ent_valid  <= '0;
            ent_done   <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            retire1    <= 1'b0;
            retire2    <= 1'b0;
            commit_cnt <= '0;
        end else begin
            retire1    <= r0 && ent_has_dest[head];
            retire2    <= r1 && ent_has_dest[head1];
            commit_cnt <= commit_c;
            // Address/data only load on a real write, otherwise hold.
            if (r0 && ent_has_dest[head]) begin
                write_addr1 <= ent_preg[head];
                write_data1 <= ent_data[head];
            end
            if (r1 && ent_has_dest[head1]) begin
                write_addr2 <= ent_preg[head1];
                write_data2 <= ent_data[head1];
            end

            // wb2 first so wb1 overrides on a shared tag.
            if (wb2_valid && ent_valid[wb2_tag]) begin
                ent_done[wb2_tag] <= 1'b1;
                ent_data[wb2_tag] <= wb2_data;
            end
            if (wb1_valid && ent_valid[wb1_tag]) begin
                ent_done[wb1_tag] <= 1'b1;
                ent_data[wb1_tag] <= wb1_data;
            end

            // Retirement invalidation after writeback: a wb to a freed tag is dropped.
            if (r0) begin
                ent_valid[head] <= 1'b0;
                ent_done[head]  <= 1'b0;
            end
            if (r1) begin
                ent_valid[head1] <= 1'b0;
                ent_done[head1]  <= 1'b0;
            end

            // Tail slot is never valid when alloc fires (full blocks alloc).
            if (alloc_fire) begin
                ent_valid[tail]    <= 1'b1;
                ent_done[tail]     <= 1'b0;
                ent_has_dest[tail] <= alloc_has_dest;
                ent_preg[tail]     <= alloc_preg;
                ent_data[tail]     <= '0;
            end

            head  <= head + TAG_W'(commit_c);
            tail  <= tail + TAG_W'(alloc_fire);
            count <= count + CNT_W'(alloc_fire) - CNT_W'(commit_c);
        end
    end

endmodule

// File: tb/tb_rob_retire_unit.sv
// Testbench for rob_retire_unit: directed scenarios plus random traffic,
// checked against a queue-based reorder buffer model.
module tb_rob_retire_unit;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_has_dest;
    logic [5:0]  alloc_preg;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic        wb1_valid;
    logic [3:0]  wb1_tag;
    logic [31:0] wb1_data;
    logic        wb2_valid;
    logic [3:0]  wb2_tag;
    logic [31:0] wb2_data;
    logic        retire1;
    logic [5:0]  write_addr1;
    logic [31:0] write_data1;
    logic        retire2;
    logic [5:0]  write_addr2;
    logic [31:0] write_data2;
    logic [1:0]  commit_cnt;
    logic [4:0]  count;
    logic        empty;
    logic        full;

    rob_retire_unit dut (
        .clk            (clk),
        .rstn           (rstn),
`ifdef ROB_FLUSH_EN
        .flush          (flush),
`endif
        .alloc_valid    (alloc_valid),
        .alloc_has_dest (alloc_has_dest),
        .alloc_preg     (alloc_preg),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .wb1_valid      (wb1_valid),
        .wb1_tag        (wb1_tag),
        .wb1_data       (wb1_data),
        .wb2_valid      (wb2_valid),
        .wb2_tag        (wb2_tag),
        .wb2_data       (wb2_data),
        .retire1        (retire1),
        .write_addr1    (write_addr1),
        .write_data1    (write_data1),
        .retire2        (retire2),
        .write_addr2    (write_addr2),
        .write_data2    (write_data2),
        .commit_cnt     (commit_cnt),
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: program-order queue of in-flight instructions.
    typedef struct {
        logic [3:0]  tag;
        logic        hd;
        logic [5:0]  preg;
        logic        done;
        logic [31:0] data;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_tail;
    int         n_tests;
    int         n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        alloc_has_dest = 1'b0;
        alloc_preg  = '0;
        wb1_valid   = 1'b0;
        wb1_tag     = '0;
        wb1_data    = '0;
        wb2_valid   = 1'b0;
        wb2_tag     = '0;
        wb2_data    = '0;
    endtask

    // One clock: check comb outputs, advance model, check registered outputs.
    task automatic tick();
        int   n;
        int   sz0;
        logic e_r1, e_r2;
        logic [5:0]  e_a1, e_a2;
        logic [31:0] e_d1, e_d2;
        logic        do_flush;
        ent_t e;
`ifdef ROB_FLUSH_EN
        do_flush = flush;
`else
        do_flush = 1'b0;
`endif
        check("alloc_ready", alloc_ready, q.size() < 16);
        check("alloc_tag", alloc_tag, m_tail);
        @(posedge clk);
        sz0 = q.size();
        e_r1 = 0; e_r2 = 0; e_a1 = 0; e_a2 = 0; e_d1 = 0; e_d2 = 0;
        if (do_flush) begin
            n = 0;
            q.delete();
            m_tail = 0;
        end else begin
            n = 0;
            while (n < 2 && n < q.size() && q[n].done) n++;
            if (n >= 1) begin e_r1 = q[0].hd; e_a1 = q[0].preg; e_d1 = q[0].data; end
            if (n >= 2) begin e_r2 = q[1].hd; e_a2 = q[1].preg; e_d2 = q[1].data; end
            for (int k = 0; k < n; k++) void'(q.pop_front());
            for (int k = 0; k < q.size(); k++) begin
                if (wb2_valid && q[k].tag == wb2_tag) begin q[k].done = 1; q[k].data = wb2_data; end
                if (wb1_valid && q[k].tag == wb1_tag) begin q[k].done = 1; q[k].data = wb1_data; end
            end
            if (alloc_valid && sz0 < 16) begin
                e.tag = m_tail; e.hd = alloc_has_dest; e.preg = alloc_preg;
                e.done = 0; e.data = 0;
                q.push_back(e);
                m_tail = m_tail + 4'd1;
            end
        end
        #1;
        check("retire1", retire1, e_r1);
        check("retire2", retire2, e_r2);
        check("commit_cnt", commit_cnt, n);
        if (e_r1) begin
            check("write_addr1", write_addr1, e_a1);
            check("write_data1", write_data1, e_d1);
        end
        if (e_r2) begin
            check("write_addr2", write_addr2, e_a2);
            check("write_data2", write_data2, e_d2);
        end
        check("count", count, q.size());
        check("empty", empty, q.size() == 0);
        check("full", full, q.size() == 16);
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        q.delete();
        m_tail = 0;
        #1;
        check("rst_retire1", retire1, 0);
        check("rst_retire2", retire2, 0);
        check("rst_commit", commit_cnt, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ready", alloc_ready, 1);
        check("rst_tag", alloc_tag, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic alloc_one(input logic hd, input logic [5:0] preg);
        idle_inputs();
        alloc_valid = 1; alloc_has_dest = hd; alloc_preg = preg;
        tick();
    endtask

    task automatic wb_one(input logic [3:0] tag, input logic [31:0] data);
        idle_inputs();
        wb1_valid = 1; wb1_tag = tag; wb1_data = data;
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_tail  = 0;
        idle_inputs();
        rstn = 1'b0;
        #2;
        do_reset();

        // Out-of-order completion, in-order dual retire.
        alloc_one(1, 6'd5);
        alloc_one(1, 6'd9);
        wb_one(4'd1, 32'h22);
        check("t2_no_early1", retire1, 0);
        wb_one(4'd0, 32'h11);
        check("t2_no_early2", retire1, 0);
        idle_inputs(); tick();
        check("t2_r1", retire1, 1);
        check("t2_a1", write_addr1, 5);
        check("t2_d1", write_data1, 32'h11);
        check("t2_r2", retire2, 1);
        check("t2_a2", write_addr2, 9);
        check("t2_d2", write_data2, 32'h22);
        check("t2_cnt", commit_cnt, 2);
        idle_inputs(); tick();
        check("t2_r1_one_cycle", retire1, 0);

        // Same-tag writeback collision: wb1 wins (tags 2, 3).
        alloc_one(1, 6'd1);
        alloc_one(1, 6'd2);
        idle_inputs();
        wb1_valid = 1; wb1_tag = 4'd3; wb1_data = 32'hAA;
        wb2_valid = 1; wb2_tag = 4'd3; wb2_data = 32'hBB;
        tick();
        wb_one(4'd2, 32'h1);
        idle_inputs(); tick();
        check("t4_r2", retire2, 1);
        check("t4_d2", write_data2, 32'hAA);

        // No-dest entry frees a slot without a register write (tags 4, 5).
        alloc_one(0, 6'd3);
        alloc_one(1, 6'd7);
        idle_inputs();
        wb1_valid = 1; wb1_tag = 4'd4; wb1_data = 32'h5;
        wb2_valid = 1; wb2_tag = 4'd5; wb2_data = 32'h77;
        tick();
        idle_inputs(); tick();
        check("t5_r1", retire1, 0);
        check("t5_r2", retire2, 1);
        check("t5_a2", write_addr2, 7);
        check("t5_cnt", commit_cnt, 2);

        // Fill to full, refused 17th alloc, wrap of tail.
        do_reset();
        for (int i = 0; i < 16; i++) alloc_one(1, 6'(i + 10));
        check("t3_full", full, 1);
        check("t3_ready", alloc_ready, 0);
        check("t3_tag_wrap", alloc_tag, 0);
        alloc_one(1, 6'd63);
        check("t3_count16", count, 16);
        wb_one(4'd0, 32'h1234);
        idle_inputs(); tick();
        check("t3_count15", count, 15);
        check("t3_ready_after", alloc_ready, 1);

`ifdef ROB_FLUSH_EN
        // Flush with 5 entries, 2 done, overriding a concurrent alloc.
        do_reset();
        for (int i = 0; i < 5; i++) alloc_one(1, 6'(i + 1));
        wb_one(4'd1, 32'h9);
        wb_one(4'd0, 32'h8);
        idle_inputs();
        flush = 1; alloc_valid = 1; alloc_has_dest = 1; alloc_preg = 6'd33;
        tick();
        check("t6_count", count, 0);
        check("t6_r1", retire1, 0);
        check("t6_tag", alloc_tag, 0);
`endif

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            alloc_valid    = ($urandom_range(0, 9) < 6);
            alloc_has_dest = ($urandom_range(0, 3) != 0);
            alloc_preg     = 6'($urandom);
            wb1_valid = ($urandom_range(0, 2) != 0);
            wb2_valid = ($urandom_range(0, 2) != 0);
            wb1_data  = $urandom;
            wb2_data  = $urandom;
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                wb1_tag = q[$urandom_range(0, q.size() - 1)].tag;
            else
                wb1_tag = 4'($urandom);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                wb2_tag = q[$urandom_range(0, q.size() - 1)].tag;
            else
                wb2_tag = 4'($urandom);
            if ($urandom_range(0, 15) == 0) wb2_tag = wb1_tag;
`ifdef ROB_FLUSH_EN
            flush = ($urandom_range(0, 49) == 0);
`endif
            tick();
        end

        // Async reset clears retire outputs without a clock edge.
        do_reset();
        alloc_one(1, 6'd3);
        wb_one(4'd0, 32'h55);
        idle_inputs(); tick();
        check("ar_r1_before", retire1, 1);
        #1;
        rstn = 1'b0;
        #1;
        check("ar_r1", retire1, 0);
        check("ar_cnt", commit_cnt, 0);
        check("ar_count", count, 0);
        check("ar_empty", empty, 1);
        #5;
        rstn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
